// File: rtl/data_memory_pkg.sv
// data_memory_pkg: size one-hot codes and FSM state encodings shared by the data RAM files.
package data_memory_pkg;
    localparam logic [2:0] SIZE_BYTE = 3'b001;
    localparam logic [2:0] SIZE_HALF = 3'b010;
    localparam logic [2:0] SIZE_WORD = 3'b100;
    typedef enum logic [1:0] {S_IDLE, S_DUMP, S_DONE, S_CLEAR} state_e;
endpackage

// File: rtl/data_mem_lane_mask.sv
// data_mem_lane_mask: maps a one-hot access size and byte lane to a lane mask and misaligned flag.
module data_mem_lane_mask
    import data_memory_pkg::*;
(
    input  logic [2:0] i_size,
    input  logic [1:0] i_lane,
    output logic [3:0] o_mask,
    output logic       o_misaligned
);
    assign o_misaligned = (i_size == SIZE_HALF && i_lane[0]) || (i_size == SIZE_WORD && i_lane != 2'b00);
    // An all-zero mask marks a rejected or illegal-size access.
    assign o_mask = o_misaligned          ? 4'b0000 :
                    i_size == SIZE_BYTE   ? 4'b0001 << i_lane :
                    i_size == SIZE_HALF   ? (i_lane[1] ? 4'b1100 : 4'b0011) :
                    i_size == SIZE_WORD   ? 4'b1111 : 4'b0000;
endmodule

// File: rtl/data_memory.sv
// data_memory: byte-addressable MEM-stage data RAM with a valid/ready dump port.
// Optional DATA_MEM_CLEAR_ON_RESET_EN zeroes every word after reset release.
module data_memory
    import data_memory_pkg::*;
#(
    parameter int NB_DATA = 32,
    parameter int NB_ADDR = 7
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_enable,
    input  logic               i_mem_read,
    input  logic               i_mem_write,
    input  logic               i_word_en,
    input  logic               i_halfword_en,
    input  logic               i_byte_en,
    input  logic [NB_ADDR-1:0] i_addr,
    input  logic [NB_DATA-1:0] i_write_data,
    output logic [NB_DATA-1:0] o_read_data,
    output logic               o_misaligned,
    input  logic               i_dump_start,
    output logic               o_dump_valid,
    input  logic               i_dump_ready,
    output logic [NB_DATA-1:0] o_dump_data,
    output logic [NB_ADDR-3:0] o_dump_addr,
    output logic               o_dump_done,
    output logic               o_busy
);
    localparam int NB_IDX = NB_ADDR - 2;
    localparam int DEPTH = 2 ** NB_IDX;
    localparam logic [NB_IDX-1:0] LAST = NB_IDX'(DEPTH - 1);
`ifdef DATA_MEM_CLEAR_ON_RESET_EN
    localparam state_e RESET_STATE = S_CLEAR;
`else
    localparam state_e RESET_STATE = S_IDLE;
`endif

    logic [NB_DATA-1:0] mem_q [DEPTH];
    state_e             state_q, state_d;
    logic [NB_IDX-1:0]  idx_q, idx_d, idx_nx;
    logic [NB_DATA-1:0] dump_data_q, dump_data_d;
    logic               valid_q, valid_d, done_q, done_d;
    logic [NB_DATA-1:0] read_data_q, read_data_d;
    logic               mis_q, mis_d;

    logic [2:0]         size;
    logic [1:0]         lane;
    logic [NB_IDX-1:0]  word_idx;
    logic [3:0]         mask;
    logic               mis, access, do_read, do_write, clear_wr;
    logic [4:0]         sh;
    logic [NB_DATA-1:0] rd_word, rd_val;
    logic               wr_en;
    logic [NB_IDX-1:0]  wr_idx;
    logic [3:0]         wr_mask;
    logic [NB_DATA-1:0] wr_data;

    assign size     = {i_word_en, i_halfword_en, i_byte_en};
    assign lane     = i_addr[1:0];
    assign word_idx = i_addr[NB_ADDR-1:2];
    assign sh       = {lane, 3'b000};

    data_mem_lane_mask u_lane_mask (
        .i_size       (size),
        .i_lane       (lane),
        .o_mask       (mask),
        .o_misaligned (mis)
    );

    assign access   = i_enable && (i_mem_read || i_mem_write) && !o_busy;
    assign do_read  = i_enable && i_mem_read && !o_busy && mask != 4'b0000;
    assign do_write = i_enable && i_mem_write && !o_busy && mask != 4'b0000;
    assign rd_word  = mem_q[word_idx] >> sh;
    assign rd_val   = size == SIZE_BYTE ? {24'b0, rd_word[7:0]} :
                      size == SIZE_HALF ? {16'b0, rd_word[15:0]} : rd_word;
`ifdef DATA_MEM_CLEAR_ON_RESET_EN
    assign clear_wr = state_q == S_CLEAR && !i_reset;
`else
    assign clear_wr = 1'b0;
`endif
    assign wr_en   = do_write || clear_wr;
    assign wr_idx  = clear_wr ? idx_q : word_idx;
    assign wr_mask = clear_wr ? 4'b1111 : mask;
    assign wr_data = clear_wr ? '0 : i_write_data << sh;
    assign idx_nx  = idx_q + 1'b1;

    // Storage is not reset; the read port and dump port both see pre-edge contents.
    always_ff @(posedge i_clock) begin
        if (wr_en)
            for (int k = 0; k < 4; k++)
                if (wr_mask[k]) mem_q[wr_idx][8*k +: 8] <= wr_data[8*k +: 8];
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        dump_data_d = dump_data_q;
        valid_d     = valid_q;
        done_d      = 1'b0;
        read_data_d = do_read ? rd_val : read_data_q;
        mis_d       = access && mis;
        case (state_q)
            S_IDLE: if (i_dump_start) begin
                state_d     = S_DUMP;
                idx_d       = '0;
                dump_data_d = mem_q[0];
                valid_d     = 1'b1;
            end
            S_DUMP: if (i_dump_ready) begin
                if (idx_q == LAST) begin
                    state_d = S_DONE;
                    valid_d = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    idx_d       = idx_nx;
                    dump_data_d = mem_q[idx_nx];
                end
            end
            S_DONE: state_d = S_IDLE;
            default: begin
                idx_d   = idx_nx;
                state_d = idx_q == LAST ? S_IDLE : S_CLEAR;
            end
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q     <= RESET_STATE;
            idx_q       <= '0;
            dump_data_q <= '0;
            valid_q     <= 1'b0;
            done_q      <= 1'b0;
            read_data_q <= '0;
            mis_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            dump_data_q <= dump_data_d;
            valid_q     <= valid_d;
            done_q      <= done_d;
            read_data_q <= read_data_d;
            mis_q       <= mis_d;
        end
    end

    assign o_read_data  = read_data_q;
    assign o_misaligned = mis_q;
    assign o_dump_valid = valid_q;
    assign o_dump_data  = dump_data_q;
    assign o_dump_addr  = idx_q;
    assign o_dump_done  = done_q;
    assign o_busy       = state_q != S_IDLE;
endmodule

// File: tb/tb_data_memory.sv
// tb_data_memory: directed self-checking bench for data_memory.
module tb_data_memory;
    localparam logic [2:0] B = 3'b001, H = 3'b010, W = 3'b100;

    logic        clk = 1'b0;
    logic        i_reset = 1'b1, i_enable = 1'b0, i_mem_read = 1'b0, i_mem_write = 1'b0;
    logic        i_word_en = 1'b0, i_halfword_en = 1'b0, i_byte_en = 1'b0;
    logic [6:0]  i_addr = '0;
    logic [31:0] i_write_data = '0;
    logic        i_dump_start = 1'b0, i_dump_ready = 1'b0;
    logic [31:0] o_read_data, o_dump_data;
    logic [4:0]  o_dump_addr;
    logic        o_misaligned, o_dump_valid, o_dump_done, o_busy;
    logic [31:0] model [32];
    int          errors = 0, checks = 0;

    always #5 clk = ~clk;

    data_memory dut (
        .i_clock(clk), .i_reset(i_reset), .i_enable(i_enable),
        .i_mem_read(i_mem_read), .i_mem_write(i_mem_write),
        .i_word_en(i_word_en), .i_halfword_en(i_halfword_en), .i_byte_en(i_byte_en),
        .i_addr(i_addr), .i_write_data(i_write_data),
        .o_read_data(o_read_data), .o_misaligned(o_misaligned),
        .i_dump_start(i_dump_start), .o_dump_valid(o_dump_valid), .i_dump_ready(i_dump_ready),
        .o_dump_data(o_dump_data), .o_dump_addr(o_dump_addr), .o_dump_done(o_dump_done),
        .o_busy(o_busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic r, input logic w, input logic [2:0] sz, input logic [6:0] a, input logic [31:0] d);
        i_enable = 1'b1; i_mem_read = r; i_mem_write = w;
        {i_word_en, i_halfword_en, i_byte_en} = sz;
        i_addr = a; i_write_data = d;
        step;
        i_enable = 1'b0; i_mem_read = 1'b0; i_mem_write = 1'b0;
    endtask

    // After reset release: with clearing enabled, busy must last exactly one cycle per word.
    task automatic after_reset;
`ifdef DATA_MEM_CLEAR_ON_RESET_EN
        int n = 0;
        while (o_busy && n < 100) begin step; n++; end
        chk("clear_cycles", 32'(n), 32'd32);
        for (int i = 0; i < 32; i++) model[i] = '0;
        op(1, 0, W, 7'h14, '0);
        chk("clear_word5", o_read_data, 32'h0);
`else
        chk("busy_after_reset", {31'b0, o_busy}, 32'h0);
`endif
    endtask

    task automatic run_dump(input logic toggle);
        int idx = 0, cyc = 0;
        logic r = 1'b1;
        while (idx < 32 && cyc < 200) begin
            i_dump_ready = r;
            chk("dump_valid", {31'b0, o_dump_valid}, 32'h1);
            chk("dump_addr", {27'b0, o_dump_addr}, 32'(idx));
            chk("dump_data", o_dump_data, model[idx]);
            step;
            if (r) idx++;
            r = toggle ? !r : 1'b1;
            cyc++;
        end
        i_dump_ready = 1'b0;
        chk("dump_beats", 32'(idx), 32'd32);
        chk("done_valid_low", {31'b0, o_dump_valid}, 32'h0);
        chk("done_pulse", {31'b0, o_dump_done}, 32'h1);
        chk("done_busy", {31'b0, o_busy}, 32'h1);
        step;
        i_enable = 1'b0; i_mem_write = 1'b0;
        chk("done_once", {31'b0, o_dump_done}, 32'h0);
        chk("idle_busy", {31'b0, o_busy}, 32'h0);
        step;
        chk("done_stays_low", {31'b0, o_dump_done}, 32'h0);
    endtask

    initial begin
        step; step;
        chk("rst_read_data", o_read_data, 32'h0);
        chk("rst_misaligned", {31'b0, o_misaligned}, 32'h0);
        chk("rst_dump_valid", {31'b0, o_dump_valid}, 32'h0);
        chk("rst_dump_done", {31'b0, o_dump_done}, 32'h0);
        i_reset = 1'b0;
        after_reset;

        op(0, 1, W, 7'h08, 32'hDEADBEEF);
        op(1, 0, B, 7'h09, '0);
        chk("byte_load", o_read_data, 32'h000000BE);
        chk("no_mis", {31'b0, o_misaligned}, 32'h0);
        op(0, 1, B, 7'h0B, 32'hFFFFFF12);
        op(1, 0, W, 7'h08, '0);
        chk("byte_store_merge", o_read_data, 32'h12ADBEEF);
        op(0, 1, W, 7'h0C, 32'h11223344);
        op(0, 1, H, 7'h0E, 32'h0000AAAA);
        op(1, 0, H, 7'h0E, '0);
        chk("half_load", o_read_data, 32'h0000AAAA);
        op(1, 0, W, 7'h0C, '0);
        chk("half_store_merge", o_read_data, 32'hAAAA3344);

        op(0, 1, H, 7'h0D, 32'h00005555);
        chk("mis_half_pulse", {31'b0, o_misaligned}, 32'h1);
        chk("mis_read_hold", o_read_data, 32'hAAAA3344);
        step;
        chk("mis_half_once", {31'b0, o_misaligned}, 32'h0);
        op(1, 0, W, 7'h0C, '0);
        chk("mis_half_nowrite", o_read_data, 32'hAAAA3344);
        op(0, 1, W, 7'h0A, 32'h99999999);
        chk("mis_word_pulse", {31'b0, o_misaligned}, 32'h1);
        op(1, 0, W, 7'h08, '0);
        chk("mis_word_once", {31'b0, o_misaligned}, 32'h0);
        chk("mis_word_nowrite", o_read_data, 32'h12ADBEEF);
        op(1, 0, W, 7'h0A, '0);
        chk("mis_load_pulse", {31'b0, o_misaligned}, 32'h1);
        op(1, 0, H, 7'h0E, '0);
        chk("mis_load_held", o_read_data, 32'h0000AAAA);

        op(1, 1, W, 7'h08, 32'hCAFEF00D);
        chk("read_before_write", o_read_data, 32'h12ADBEEF);
        op(1, 0, W, 7'h08, '0);
        chk("rbw_new_data", o_read_data, 32'hCAFEF00D);
        op(0, 1, 3'b011, 7'h08, 32'h0);
        chk("bad_size_no_flag", {31'b0, o_misaligned}, 32'h0);
        i_mem_write = 1'b1; i_addr = 7'h08; i_write_data = '0; {i_word_en, i_halfword_en, i_byte_en} = W;
        step;
        i_mem_write = 1'b0;
        op(1, 0, W, 7'h08, '0);
        chk("bad_size_and_disabled", o_read_data, 32'hCAFEF00D);
        op(1, 0, 3'b000, 7'h0C, '0);
        chk("no_size_read_hold", o_read_data, 32'hCAFEF00D);

        for (int i = 0; i < 32; i++) begin
            model[i] = (32'h01010101 * i) ^ 32'h5A0000C3;
            op(0, 1, W, 7'(i * 4), model[i]);
        end

        i_dump_start = 1'b1;
        step;
        i_dump_start = 1'b0;
        i_enable = 1'b1; i_mem_write = 1'b1; {i_word_en, i_halfword_en, i_byte_en} = W;
        i_addr = 7'h00; i_write_data = 32'hFFFFFFFF;
        run_dump(1'b1);
        op(1, 0, W, 7'h00, '0);
        chk("busy_blocks_write", o_read_data, model[0]);

        i_dump_start = 1'b1;
        step;
        i_dump_start = 1'b0;
        i_dump_ready = 1'b1;
        for (int i = 0; i < 5; i++) step;
        chk("beat5_addr", {27'b0, o_dump_addr}, 32'd5);
        i_reset = 1'b1;
        step;
        i_reset = 1'b0;
        i_dump_ready = 1'b0;
        chk("rst_mid_valid", {31'b0, o_dump_valid}, 32'h0);
        chk("rst_mid_done", {31'b0, o_dump_done}, 32'h0);
        after_reset;
        i_dump_start = 1'b1;
        step;
        i_dump_start = 1'b0;
        run_dump(1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
